axi_full_burst_master: RTL

- Self-checking AXI4-full master. It sits directly upstream of the AXI4-full slave (my_axi_full_s) and replaces the VIP master in hardware builds.
- On a start pulse it issues one INCR write burst of a counting pattern, then one INCR read burst from the same address.
- It compares every read beat against the pattern and reports done and error.

---
 rtl/axi_full_mst_pkg.sv | 22 ++
 rtl/axi_burst_pattern_gen.sv | 34 +++
 rtl/axi_full_burst_master.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_full_mst_pkg.sv
// Shared types and helpers for the AXI4-full burst master.
// FSM states, AXI encodings and the AxSIZE-from-width function.
package axi_full_mst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } mst_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_burst_pattern_gen.sv
// Beat counter producing the counting pattern (k+1) and last-beat flag.
// One instance drives write data, another supplies read expectations.
module axi_burst_pattern_gen
    import axi_full_mst_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  adv,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    localparam int CW = 9;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign data = DATA_WIDTH'(cnt) + DATA_WIDTH'(1);
    assign last = (cnt == CW'(BURST_LEN - 1));

endmodule

// File: rtl/axi_full_burst_master.sv
// Self-checking AXI4-full master: one INCR write burst, then a checked readback.
// Define AXI_MST_PERF_CNT_EN to add the TXN_CYCLES busy-cycle counter.
module axi_full_burst_master
    import axi_full_mst_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_BURST_LEN  = 8
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
`ifdef AXI_MST_PERF_CNT_EN
    output logic [31:0]                     TXN_CYCLES,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;

    mst_state_e state, state_nxt;

    logic          init_q;
    logic          start_q;
    logic          start_ok;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_exp;
    logic          wr_last;
    logic          rd_last;
    logic          w_hs;
    logic          b_hs;
    logic          r_hs;
    logic          rd_bad;

    assign M_AXI_AWADDR  = C_M_TARGET_SLAVE_BASE_ADDR;
    assign M_AXI_ARADDR  = C_M_TARGET_SLAVE_BASE_ADDR;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = axi_size(C_M_AXI_DATA_WIDTH);
    assign M_AXI_ARSIZE  = axi_size(C_M_AXI_DATA_WIDTH);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_WSTRB   = '1;

    assign M_AXI_AWVALID = (state == WR_ADDR);
    assign M_AXI_WVALID  = (state == WR_DATA);
    assign M_AXI_WDATA   = wr_data;
    assign M_AXI_WLAST   = wr_last & M_AXI_WVALID;
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign M_AXI_ARVALID = (state == RD_ADDR);
    assign M_AXI_RREADY  = (state == RD_DATA);

    assign start_ok = start_q & ((state == IDLE) | (state == DONE));
    assign w_hs     = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs     = M_AXI_BREADY & M_AXI_BVALID;
    assign r_hs     = M_AXI_RREADY & M_AXI_RVALID;
    assign rd_bad   = (M_AXI_RDATA != rd_exp)
                    | (M_AXI_RRESP != AXI_RESP_OKAY)
                    | (M_AXI_RLAST != rd_last);

    axi_burst_pattern_gen #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (C_M_AXI_BURST_LEN)
    ) u_wr_gen (
        .clk  (M_AXI_ACLK),
        .rst  (M_AXI_ARESET),
        .clr  (start_ok),
        .adv  (w_hs),
        .data (wr_data),
        .last (wr_last)
    );

    axi_burst_pattern_gen #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (C_M_AXI_BURST_LEN)
    ) u_rd_gen (
        .clk  (M_AXI_ACLK),
        .rst  (M_AXI_ARESET),
        .clr  (start_ok),
        .adv  (r_hs),
        .data (rd_exp),
        .last (rd_last)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            init_q   <= 1'b0;
            start_q  <= 1'b0;
            state    <= IDLE;
            TXN_DONE <= 1'b0;
            ERROR    <= 1'b0;
        end else begin
            init_q  <= INIT_AXI_TXN;
            start_q <= INIT_AXI_TXN & ~init_q;
            state   <= state_nxt;
            if (start_ok) begin
                TXN_DONE <= 1'b0;
                ERROR    <= 1'b0;
            end else begin
                if (b_hs && (M_AXI_BRESP != AXI_RESP_OKAY)) ERROR <= 1'b1;
                if (r_hs && rd_bad) ERROR <= 1'b1;
                if (r_hs && rd_last) TXN_DONE <= 1'b1;
            end
        end
    end

    // Read burst length is counted locally; RLAST is only checked.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = WR_ADDR;
            WR_ADDR: if (M_AXI_AWREADY) state_nxt = WR_DATA;
            WR_DATA: if (w_hs && wr_last) state_nxt = WR_RESP;
            WR_RESP: if (M_AXI_BVALID) state_nxt = RD_ADDR;
            RD_ADDR: if (M_AXI_ARREADY) state_nxt = RD_DATA;
            RD_DATA: if (r_hs && rd_last) state_nxt = DONE;
            DONE:    if (start_ok) state_nxt = WR_ADDR;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef AXI_MST_PERF_CNT_EN
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            TXN_CYCLES <= '0;
        end else if (start_ok) begin
            TXN_CYCLES <= '0;
        end else if ((state != IDLE) && (state != DONE)
                     && (TXN_CYCLES != '1)) begin
            TXN_CYCLES <= TXN_CYCLES + 32'd1;
        end
    end
`endif

endmodule
